// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and stall-counter width.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    StRun   = 1'b0,
    StStall = 1'b1
  } state_e;

  localparam int unsigned StallCntW = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts inc_i cycles and sticks at all-ones instead of wrapping.
module pipeline_hazard_ctrl_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use bubbles, branch squash,
// memory-not-ready freeze, and a saturating count of cycles with the PC held.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_LEN = 3,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned CNT_LEN      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_LEN-1:0] ID_src1,
  input  logic [REG_ADDR_LEN-1:0] ID_src2,
  input  logic                    ID_uses_src1,
  input  logic                    ID_uses_src2,
  input  logic [REG_ADDR_LEN-1:0] EX_dst,
  input  logic                    EX_MEM_read,
  input  logic                    EX_RF_write_en,
  input  logic                    EX_branch_taken,
  input  logic                    MEM_req,
  input  logic                    MEM_ready,
  output logic                    PC_en,
  output logic                    IF_ID_en,
  output logic                    ID_EX_en,
  output logic                    EX_MEM_en,
  output logic                    MEM_WB_en,
  output logic                    IF_ID_flush,
  output logic                    ID_EX_flush,
  output logic [CNT_LEN-1:0]      stall_cycles,
  output logic                    busy
);

  localparam logic [StallCntW-1:0] StallInit = StallCntW'(LOAD_LATENCY - 1);

  state_e               state_q, state_d;
  logic [StallCntW-1:0] cnt_q, cnt_d;
  logic                 load_use, mem_freeze;

  assign load_use = EX_MEM_read & EX_RF_write_en &
                    ((ID_uses_src1 & (ID_src1 == EX_dst)) |
                     (ID_uses_src2 & (ID_src2 == EX_dst)));
  assign mem_freeze = MEM_req & ~MEM_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A freeze holds state and cnt so the stall is extended rather than consumed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_freeze) begin
      unique case (state_q)
        StRun: begin
          if (!EX_branch_taken && load_use && (LOAD_LATENCY > 1)) begin
            state_d = StStall;
            cnt_d   = StallInit;
          end
        end
        StStall: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == StallCntW'(1)) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    PC_en       = 1'b1;
    IF_ID_en    = 1'b1;
    ID_EX_en    = 1'b1;
    EX_MEM_en   = 1'b1;
    MEM_WB_en   = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    busy        = (state_q == StStall);
    if (rst) begin
      PC_en       = 1'b0;
      IF_ID_en    = 1'b0;
      ID_EX_en    = 1'b0;
      EX_MEM_en   = 1'b0;
      MEM_WB_en   = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      busy        = 1'b0;
    end else if (mem_freeze) begin
      PC_en     = 1'b0;
      IF_ID_en  = 1'b0;
      ID_EX_en  = 1'b0;
      EX_MEM_en = 1'b0;
      MEM_WB_en = 1'b0;
    end else if ((state_q == StRun) && EX_branch_taken) begin
      // The ID instruction is wrong-path, so any load-use match on it is moot.
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if ((state_q == StStall) || load_use) begin
      PC_en       = 1'b0;
      IF_ID_en    = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  pipeline_hazard_ctrl_sat_counter #(
    .Width (CNT_LEN)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (~PC_en),
    .count_o (stall_cycles)
  );

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the five-stage pipeline. It owns the enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It inserts bubbles on load-use hazards, squashes wrong-path instructions on taken branches, and freezes the pipeline while data memory is not ready. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- REG_ADDR_LEN, 3: register-file address width.
- LOAD_LATENCY, 1: bubbles inserted per load-use hazard (1..15).
- CNT_LEN, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ID_src1, ID_src2  in  REG_ADDR_LEN  source register addresses decoded in ID.
- ID_uses_src1, ID_uses_src2  in  1  the ID instruction actually reads src1 / src2.
- EX_dst  in  REG_ADDR_LEN  destination register of the instruction in EX.
- EX_MEM_read, EX_RF_write_en  in  1  MEM_read and RF_write_en of the instruction in EX (ID/EX register outputs).
- EX_branch_taken  in  1  taken branch resolved in EX this cycle.
- MEM_req  in  1  MEM stage holds a load or store.
- MEM_ready  in  1  data memory completes the access this cycle.
- PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en  out  1  register write enables.
- IF_ID_flush, ID_EX_flush  out  1  synchronous clear to bubble. Flush has priority over enable in the target register.
- stall_cycles  out  CNT_LEN  saturating count of cycles with PC_en=0.
- busy  out  1  high in STALL state.

## Operation
- States: RUN and STALL. A down-counter cnt of 4 bits.
- load_use = EX_MEM_read & EX_RF_write_en & ((ID_uses_src1 & ID_src1==EX_dst) | (ID_uses_src2 & ID_src2==EX_dst)).
- mem_freeze = MEM_req & ~MEM_ready.
- Priority, evaluated combinationally each cycle in order: rst > mem_freeze > EX_branch_taken > STALL/load_use > normal.
- rst: all enables 0, both flushes 1, busy 0.
- mem_freeze, in any state: all five enables 0, no flush. State and cnt hold.
- Branch in RUN: all enables 1, IF_ID_flush=1, ID_EX_flush=1. load_use is ignored because the ID instruction is wrong-path.
- load_use in RUN (no branch):
  - PC_en=0, IF_ID_en=0, ID_EX_flush=1. EX_MEM_en and MEM_WB_en stay 1.
  - If LOAD_LATENCY>1: go to STALL with cnt=LOAD_LATENCY-1.
- STALL:
  - Outputs are the same as the load_use case, independent of load_use.
  - cnt decrements on each unfrozen cycle. When cnt==1 on an unfrozen cycle, return to RUN.
  - EX holds a bubble here, so EX_branch_taken is a protocol error and is ignored.
- Normal: all enables 1, no flush.
- stall_cycles increments by 1 on every cycle with rst=0 and PC_en=0. It saturates at all-ones with no wrap.
- Hazard compare uses full REG_ADDR_LEN equality. Register 0 is not special.

## Timing
- Enable and flush outputs are combinational from state, cnt and the current inputs. Same-cycle response, zero latency.
- State, cnt and stall_cycles are registered.
- Reset values, applied at the first edge with rst=1: state=RUN, cnt=0, stall_cycles=0, busy=0.
- While rst is high the outputs are forced to: enables 0, flushes 1.
- rst during STALL or during a freeze: RUN on the next cycle, with no residual stall.
- A single load-use hazard costs exactly LOAD_LATENCY cycles of PC_en=0 plus any freeze cycles.
- A freeze extends STALL without consuming cnt.
- Simultaneous mem_freeze and EX_branch_taken: freeze wins. The flush happens on the first unfrozen cycle, since the EX inputs are held.

## Structure
- Add `REG_ADDR_LEN and the state encoding (RUN=1'b0, STALL=1'b1) to defines.sv.
- One sub-module is natural: sat_counter (parameterised width, inc, rst). It implements stall_cycles.
- Everything else is a single always_ff for state/cnt plus an always_comb for the outputs.

## Test plan
- Reset, then idle with no hazard inputs → all enables 1, flushes 0. stall_cycles stays 0. During rst, enables are 0 and flushes 1.
- LOAD_LATENCY=1; EX load to r3, ID reads r3 via src2 → one cycle of PC_en=0, IF_ID_en=0, ID_EX_flush=1. Next cycle is normal. stall_cycles=1.
- LOAD_LATENCY=3, same hazard → three stall cycles, busy high on cycles 2–3. Then RUN; stall_cycles=3.
- Load-use and EX_branch_taken in the same cycle → no stall, both flushes 1, all enables 1.
- In STALL with cnt=2, MEM_req=1 and MEM_ready=0 for 4 cycles → all enables 0 for 4 cycles and cnt holds. Then 2 more stall cycles; stall_cycles totals LOAD_LATENCY+4.
- rst asserted mid-STALL → next cycle state=RUN, stall_cycles=0. Force 2^CNT_LEN+5 freeze cycles → stall_cycles saturates at all-ones.
